uart_tx_arbiter: RTL and testbench

//   Shares the single UART transmitter among N byte requesters, e.g. CPU console, boot monitor, debug dump.

---
 rtl/uart_tx_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among N_REQ byte sources.
// Round-robin arbitration with a message lock, so a multi-byte string from
// one source is never interleaved with bytes from another. After each write
// the arbiter polls the UART idle flag itself. It then waits a guard interval
// that covers the stop bit before it offers the next byte.
module uart_tx_arbiter #(
    parameter int N_REQ          = 2,
    parameter int GUARD_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [2:0]         uart_a,
    output logic [31:0]        uart_d,
    output logic               uart_we,
    input  logic [31:0]        uart_spo,
    output logic [2:0]         grant_id,
    output logic               locked,
    output logic               busy,
    output logic               err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_SETTLE,
        S_WAIT,
        S_GUARD
    } state_t;

    state_t      r_state,  w_state_nxt;
    logic [2:0]  r_rr_ptr, w_rr_ptr_nxt;
    logic [2:0]  r_grant,  w_grant_nxt;
    logic        r_locked, w_locked_nxt;
    logic        r_err,    w_err_nxt;
    logic [31:0] r_cnt,    w_cnt_nxt;

    logic        w_uart_idle;
    logic        w_unused_spo;
    logic        w_sel_valid;
    logic        w_sel_last;
    logic [7:0]  w_sel_data;
    logic        w_cand_found;
    logic [2:0]  w_cand_id;

    // Only the tx-idle bit of the status word matters here.
    assign w_uart_idle  = uart_spo[24];
    assign w_unused_spo = ^{uart_spo[31:25], uart_spo[23:0]};

    // Route the request lines of the granted source.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant == 3'(i)) begin
                w_sel_valid = req_valid[i];
                w_sel_last  = req_last[i];
                w_sel_data  = req_data[8*i +: 8];
            end
        end
    end

    // Pick the next source. Under a lock only the owner may be chosen.
    // Otherwise take the first valid source, starting at rr_ptr and wrapping.
    always_comb begin
        w_cand_found = 1'b0;
        w_cand_id    = r_grant;
        if (r_locked) begin
            w_cand_found = w_sel_valid;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                for (int j = 0; j < N_REQ; j++) begin
                    // (rr_ptr + k) mod N_REQ == j, with rr_ptr and k both below N_REQ
                    if (!w_cand_found && req_valid[j] &&
                        ((int'(r_rr_ptr) + k == j) || (int'(r_rr_ptr) + k == j + N_REQ))) begin
                        w_cand_found = 1'b1;
                        w_cand_id    = 3'(j);
                    end
                end
            end
        end
    end

    // Next-state logic and Moore outputs of the write/poll/guard sequence.
    always_comb begin
        w_state_nxt  = r_state;
        w_rr_ptr_nxt = r_rr_ptr;
        w_grant_nxt  = r_grant;
        w_locked_nxt = r_locked;
        w_err_nxt    = r_err;
        w_cnt_nxt    = r_cnt;
        uart_we      = 1'b0;
        uart_a       = 3'b010;
        uart_d       = 32'h0;
        req_ready    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_uart_idle && w_cand_found) begin
                    w_grant_nxt = w_cand_id;
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                uart_we = 1'b1;
                uart_a  = 3'b000;
                uart_d  = {w_sel_data, 24'h0};
                for (int i = 0; i < N_REQ; i++) begin
                    req_ready[i] = (r_grant == 3'(i));
                end
                w_locked_nxt = ~w_sel_last;
                if (w_sel_last) begin
                    // The source that just finished its message drops to lowest priority.
                    w_rr_ptr_nxt = (r_grant == 3'(N_REQ - 1)) ? 3'd0 : r_grant + 3'd1;
                end
                w_cnt_nxt   = 32'h0;
                w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                // The UART clears its idle flag one cycle after the write, so skip one sample.
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_uart_idle) begin
                    w_cnt_nxt   = 32'h0;
                    w_state_nxt = (GUARD_CYCLES == 0) ? S_IDLE : S_GUARD;
                end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == 32'(TIMEOUT_CYCLES - 1))) begin
                    w_err_nxt    = 1'b1;
                    w_locked_nxt = 1'b0;
                    w_cnt_nxt    = 32'h0;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 32'h1;
                end
            end
            S_GUARD: begin
                if (r_cnt == 32'(GUARD_CYCLES - 1)) begin
                    w_cnt_nxt   = 32'h0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 32'h1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and bookkeeping registers, with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= 3'd0;
            r_grant  <= 3'd0;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= 32'h0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_grant  <= w_grant_nxt;
            r_locked <= w_locked_nxt;
            r_err    <= w_err_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign grant_id    = r_grant;
    assign locked      = r_locked;
    assign busy        = (r_state != S_IDLE);
    assign err_timeout = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter. A stimulus process feeds per-source byte
// queues and pushes each presented byte into a per-source expectation queue.
// A monitor holds a small arbitration model, works out which source must own
// each UART write, and pops and compares that source's expected byte.
module tb_uart_tx_arbiter;

    localparam int N       = 3;
    localparam int GUARD   = 4;
    localparam int TIMEOUT = 128;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } item_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [2:0]     uart_a;
    logic [31:0]    uart_d;
    logic           uart_we;
    logic [31:0]    uart_spo;
    logic [2:0]     grant_id;
    logic           locked;
    logic           busy;
    logic           err_timeout;

    uart_tx_arbiter #(
        .N_REQ(N),
        .GUARD_CYCLES(GUARD),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .uart_a(uart_a),
        .uart_d(uart_d),
        .uart_we(uart_we),
        .uart_spo(uart_spo),
        .grant_id(grant_id),
        .locked(locked),
        .busy(busy),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // UART model: busy for uart_frame cycles after a write; uart_hold forces busy.
    int   uart_frame = 12;
    logic uart_hold  = 1'b0;
    int   uart_cnt   = 0;
    logic uart_idle_m;

    always @(posedge clk) begin
        if (rst)             uart_cnt <= 0;
        else if (uart_we)    uart_cnt <= uart_frame;
        else if (uart_cnt > 0) uart_cnt <= uart_cnt - 1;
    end
    assign uart_idle_m = (uart_cnt == 0) && !uart_hold;
    assign uart_spo    = {7'h7F, uart_idle_m, 24'hA5A5A5};

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    item_t      tx_q  [N][$];
    item_t      exp_q [N][$];
    logic [7:0] wr_log[$];
    int         gap   [N];
    logic       done  [N];
    int         max_gap = 0;

    logic        smp_busy, smp_we, smp_locked, smp_err;
    logic [2:0]  smp_grant, smp_a;
    logic [31:0] smp_d;
    logic [N-1:0] smp_ready;

    // One clock of stimulus: sample at negedge, update inputs just after posedge.
    task automatic step();
        item_t it;
        @(negedge clk);
        smp_busy   = busy;
        smp_we     = uart_we;
        smp_locked = locked;
        smp_err    = err_timeout;
        smp_grant  = grant_id;
        smp_a      = uart_a;
        smp_d      = uart_d;
        smp_ready  = req_ready;
        for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) done[i] = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (done[i]) begin
                req_valid[i] = 1'b0;
                done[i]      = 1'b0;
                gap[i]       = int'($urandom_range(max_gap, 0));
            end
            if (!req_valid[i]) begin
                if (gap[i] > 0) begin
                    gap[i]--;
                end else if (tx_q[i].size() > 0) begin
                    it = tx_q[i].pop_front();
                    req_data[8*i +: 8] = it.data;
                    req_last[i]        = it.last;
                    req_valid[i]       = 1'b1;
                    exp_q[i].push_back(it);
                end
            end
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) step();
        rst = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int  n;
        logic fin;
        n   = 0;
        fin = 1'b0;
        while (!fin && n < budget) begin
            step();
            n++;
            fin = !smp_busy && (req_valid == '0);
            for (int i = 0; i < N; i++) if (tx_q[i].size() != 0) fin = 1'b0;
        end
        check({name, "_drained"}, 32'(fin), 1);
    endtask

    task automatic check_log(input string name, input logic [7:0] exp[$]);
        check({name, "_count"}, wr_log.size(), exp.size());
        for (int k = 0; k < exp.size(); k++) begin
            check($sformatf("%s_byte%0d", name, k),
                  (k < wr_log.size()) ? 32'(wr_log[k]) : 32'hDEAD, 32'(exp[k]));
        end
    endtask

    function automatic item_t mk(input logic [7:0] d, input logic l);
        item_t it;
        it.data = d;
        it.last = l;
        return it;
    endfunction

    // Monitor: arbitration model plus scoreboard pop on every UART write.
    initial begin : monitor
        int           m_rr;
        logic         m_locked;
        int           m_owner;
        logic [N-1:0] v_prev;
        int           w;
        item_t        it;
        m_rr     = 0;
        m_locked = 1'b0;
        m_owner  = 0;
        v_prev   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_rr     = 0;
                m_locked = 1'b0;
            end else if (uart_we) begin
                w = -1;
                if (m_locked) begin
                    if (v_prev[m_owner]) w = m_owner;
                end else begin
                    for (int k = 0; k < N; k++) begin
                        if (w < 0 && v_prev[(m_rr + k) % N]) w = (m_rr + k) % N;
                    end
                end
                if (w < 0) begin
                    check("write_without_eligible_request", 32'(uart_we), 0);
                end else begin
                    check("ready_onehot", 32'(req_ready), 32'(1 << w));
                    check("grant_id", 32'(grant_id), 32'(w));
                    check("uart_a_write", 32'(uart_a), 0);
                    check("uart_idle_at_we", 32'(uart_idle_m), 1);
                    check("exp_available", 32'(exp_q[w].size() > 0), 1);
                    if (exp_q[w].size() > 0) begin
                        it = exp_q[w].pop_front();
                        check("uart_d", uart_d, {it.data, 24'h0});
                        if (it.last) begin
                            m_locked = 1'b0;
                            m_rr     = (w + 1) % N;
                        end else begin
                            m_locked = 1'b1;
                            m_owner  = w;
                        end
                    end
                end
                wr_log.push_back(uart_d[31:24]);
            end else begin
                check("idle_uart_a", 32'(uart_a), 32'h2);
                check("idle_uart_d_ready", uart_d | 32'(req_ready), 0);
            end
            v_prev = req_valid;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int   first_we;
        int   busy_cnt;
        logic seen_busy;
        logic err_a, err_b, lock_b, busy_b;
        int   total;
        int   r, len;
        logic [7:0] exp[$];

        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int i = 0; i < N; i++) begin
            gap[i]  = 0;
            done[i] = 1'b0;
        end

        // Reset state
        do_reset(3);
        check("rst_busy", 32'(smp_busy), 0);
        check("rst_locked", 32'(smp_locked), 0);
        check("rst_grant", 32'(smp_grant), 0);
        check("rst_err", 32'(smp_err), 0);
        check("rst_we", 32'(smp_we), 0);
        check("rst_ready", 32'(smp_ready), 0);
        check("rst_uart_a", 32'(smp_a), 32'h2);
        check("rst_uart_d", smp_d, 0);

        // Single byte: latency and busy length
        uart_frame = 100;
        wr_log     = {};
        tx_q[0].push_back(mk(8'h55, 1'b1));
        step();
        first_we  = -1;
        busy_cnt  = 0;
        seen_busy = 1'b0;
        for (int s = 1; s < 400; s++) begin
            step();
            if (smp_we && first_we < 0) first_we = s;
            if (smp_busy) begin
                busy_cnt++;
                seen_busy = 1'b1;
            end else if (seen_busy) begin
                break;
            end
        end
        check("t1_accept_latency", 32'(first_we), 2);
        check("t1_busy_cycles", 32'(busy_cnt), 32'(102 + GUARD));
        exp = {8'h55};
        check_log("t1", exp);

        // Simultaneous single-byte messages alternate
        do_reset(2);
        uart_frame = 20;
        wr_log     = {};
        tx_q[0].push_back(mk(8'hA1, 1'b1));
        tx_q[0].push_back(mk(8'hA1, 1'b1));
        tx_q[1].push_back(mk(8'hB2, 1'b1));
        tx_q[1].push_back(mk(8'hB2, 1'b1));
        drain("t2", 1000);
        exp = {8'hA1, 8'hB2, 8'hA1, 8'hB2};
        check_log("t2", exp);

        // Locked message is not interleaved
        do_reset(2);
        wr_log = {};
        tx_q[1].push_back(mk(8'h48, 1'b0));
        tx_q[1].push_back(mk(8'h49, 1'b0));
        tx_q[1].push_back(mk(8'h0A, 1'b1));
        step();
        tx_q[0].push_back(mk(8'h58, 1'b1));
        drain("t3", 1000);
        exp = {8'h48, 8'h49, 8'h0A, 8'h58};
        check_log("t3", exp);

        // UART never returns idle: timeout
        do_reset(2);
        wr_log = {};
        tx_q[0].push_back(mk(8'h42, 1'b0));
        first_we = -1;
        for (int s = 0; s < 20 && first_we < 0; s++) begin
            step();
            if (smp_we) first_we = s;
        end
        check("t4_write_seen", 32'(first_we >= 0), 1);
        uart_hold = 1'b1;
        err_a  = 1'b1;
        err_b  = 1'b0;
        lock_b = 1'b1;
        busy_b = 1'b1;
        for (int s = 1; s <= TIMEOUT + 2; s++) begin
            step();
            if (s == TIMEOUT + 1) err_a = smp_err;
            if (s == TIMEOUT + 2) begin
                err_b  = smp_err;
                lock_b = smp_locked;
                busy_b = smp_busy;
            end
        end
        check("t4_err_not_early", 32'(err_a), 0);
        check("t4_err_set", 32'(err_b), 1);
        check("t4_lock_cleared", 32'(lock_b), 0);
        check("t4_back_idle", 32'(busy_b), 0);
        uart_hold = 1'b0;
        repeat (10) step();
        check("t4_err_sticky", 32'(smp_err), 1);
        do_reset(2);
        check("t4_err_cleared_by_rst", 32'(smp_err), 0);

        // Reset during WAIT
        uart_frame = 30;
        wr_log     = {};
        tx_q[0].push_back(mk(8'h50, 1'b1));
        first_we = -1;
        for (int s = 0; s < 20 && first_we < 0; s++) begin
            step();
            if (smp_we) first_we = s;
        end
        tx_q[1].push_back(mk(8'h51, 1'b1));
        repeat (5) step();
        check("t5_in_wait_busy", 32'(smp_busy), 1);
        rst = 1'b1;
        tx_q[0].push_back(mk(8'h52, 1'b1));
        step();
        step();
        check("t5_rst_busy", 32'(smp_busy), 0);
        check("t5_rst_locked", 32'(smp_locked), 0);
        check("t5_rst_grant", 32'(smp_grant), 0);
        check("t5_rst_we", 32'(smp_we), 0);
        check("t5_rst_uart_a", 32'(smp_a), 32'h2);
        rst    = 1'b0;
        wr_log = {};
        drain("t5", 1000);
        exp = {8'h52, 8'h51};
        check_log("t5", exp);

        // Randomized multi-source traffic with random gaps
        do_reset(2);
        uart_frame = 12;
        max_gap    = 3;
        wr_log     = {};
        total      = 0;
        while (total < 32) begin
            r   = int'($urandom_range(N - 1, 0));
            len = int'($urandom_range(3, 1));
            for (int b = 0; b < len; b++) begin
                tx_q[r].push_back(mk(8'($urandom), b == len - 1));
                total++;
            end
        end
        drain("t6", 5000);
        check("t6_write_count", wr_log.size(), 32'(total));

        total = 0;
        for (int i = 0; i < N; i++) total += exp_q[i].size();
        check("scoreboard_empty", 32'(total), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
